// File: rtl/note_tone_gen.sv
// Priority-selects one of seven note enables and divides clk to that note's pitch.
// A release timer keeps the tone running after the keys drop; spk, active and note_idx are registered.
module note_tone_gen #(
  parameter int CLK_HZ         = 50000000,
  parameter int RELEASE_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       ind,
  input  logic       ine,
  input  logic       inf,
  input  logic       ing,
  input  logic       ina,
  input  logic       inb,
  input  logic       mute,
  output logic       spk,
  output logic       active,
  output logic [2:0] note_idx
);

  localparam int HALF_C = CLK_HZ / (2 * 262);
  localparam int HALF_D = CLK_HZ / (2 * 294);
  localparam int HALF_E = CLK_HZ / (2 * 330);
  localparam int HALF_F = CLK_HZ / (2 * 349);
  localparam int HALF_G = CLK_HZ / (2 * 392);
  localparam int HALF_A = CLK_HZ / (2 * 440);
  localparam int HALF_B = CLK_HZ / (2 * 494);

  // C is the lowest pitch, so it has the largest half-period; B has the smallest.
  localparam int CW = (HALF_C > 1) ? $clog2(HALF_C) : 1;
  localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam bit HAS_RELEASE = (RELEASE_CYCLES > 0);
  localparam logic [RW-1:0] REL_LOAD = HAS_RELEASE ? RW'(RELEASE_CYCLES - 1) : '0;

  if (HALF_B < 1) begin : g_half_check
    $error("note_tone_gen: CLK_HZ too low, a half-period is below 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nx;
  logic [CW-1:0]   w_cnt_run;
  logic            r_tone;
  logic            w_tone_nx;
  logic            w_tone_run;
  logic [RW-1:0]   r_rel;
  logic [RW-1:0]   w_rel_nx;
  logic [2:0]      r_note;
  logic [2:0]      w_note_nx;
  logic [2:0]      w_sel;
  logic            w_any;
  logic [6:0]      w_keys;
  logic            r_spk;
  logic            r_active;

  function automatic logic [CW-1:0] half_m1(input logic [2:0] idx);
    case (idx)
      3'd0:    half_m1 = CW'(HALF_C - 1);
      3'd1:    half_m1 = CW'(HALF_D - 1);
      3'd2:    half_m1 = CW'(HALF_E - 1);
      3'd3:    half_m1 = CW'(HALF_F - 1);
      3'd4:    half_m1 = CW'(HALF_G - 1);
      3'd5:    half_m1 = CW'(HALF_A - 1);
      3'd6:    half_m1 = CW'(HALF_B - 1);
      default: half_m1 = CW'(HALF_C - 1);
    endcase
  endfunction

  assign w_keys = {inb, ina, ing, inf, ine, ind, inc};
  assign w_any  = |w_keys;

  // Lowest set index wins, so C has the highest priority.
  always_comb begin
    w_sel = 3'd0;
    if      (w_keys[0]) w_sel = 3'd0;
    else if (w_keys[1]) w_sel = 3'd1;
    else if (w_keys[2]) w_sel = 3'd2;
    else if (w_keys[3]) w_sel = 3'd3;
    else if (w_keys[4]) w_sel = 3'd4;
    else if (w_keys[5]) w_sel = 3'd5;
    else if (w_keys[6]) w_sel = 3'd6;
    else                w_sel = 3'd0;
  end

  // One divider step on the held note, shared by PLAY and RELEASE.
  always_comb begin
    w_cnt_run  = r_cnt;
    w_tone_run = r_tone;
    if (r_cnt == half_m1(r_note)) begin
      w_cnt_run  = '0;
      w_tone_run = ~r_tone;
    end else begin
      w_cnt_run  = r_cnt + CW'(1);
      w_tone_run = r_tone;
    end
  end

  // Next-state logic; any key press restarts the phase on the selected note.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_tone_nx  = r_tone;
    w_rel_nx   = r_rel;
    w_note_nx  = r_note;
    case (r_state)
      ST_IDLE: begin
        w_tone_nx = 1'b0;
        if (w_any) begin
          w_note_nx  = w_sel;
          w_cnt_nx   = '0;
          w_state_nx = ST_PLAY;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (w_any) begin
          if (w_sel == r_note) begin
            w_cnt_nx  = w_cnt_run;
            w_tone_nx = w_tone_run;
          end else begin
            w_note_nx = w_sel;
            w_cnt_nx  = '0;
            w_tone_nx = 1'b0;
          end
        end else if (!HAS_RELEASE) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
          w_tone_nx  = 1'b0;
        end else begin
          w_state_nx = ST_RELEASE;
          w_rel_nx   = REL_LOAD;
          w_cnt_nx   = w_cnt_run;
          w_tone_nx  = w_tone_run;
        end
      end
      ST_RELEASE: begin
        if (w_any) begin
          w_state_nx = ST_PLAY;
          w_note_nx  = w_sel;
          w_cnt_nx   = '0;
          w_tone_nx  = 1'b0;
        end else if (r_rel == '0) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
          w_tone_nx  = 1'b0;
        end else begin
          w_rel_nx   = r_rel - RW'(1);
          w_cnt_nx   = w_cnt_run;
          w_tone_nx  = w_tone_run;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
        w_tone_nx  = 1'b0;
      end
    endcase
  end

  // State and output registers; mute only gates the registered speaker drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_tone   <= 1'b0;
      r_rel    <= '0;
      r_note   <= 3'd0;
      r_spk    <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_tone   <= w_tone_nx;
      r_rel    <= w_rel_nx;
      r_note   <= w_note_nx;
      r_spk    <= r_tone & ~mute;
      r_active <= (w_state_nx != ST_IDLE);
    end
  end

  assign spk      = r_spk;
  assign active   = r_active;
  assign note_idx = r_note;

endmodule

// File: tb/tb_note_tone_gen.sv
// Self-checking bench for note_tone_gen: directed scenarios plus random key traffic,
// compared cycle by cycle against an elapsed-time model of the tone.
module tb_note_tone_gen;

  localparam int CLK_HZ = 5240;
  localparam int REL    = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inc = 1'b0, ind = 1'b0, ine = 1'b0, inf = 1'b0;
  logic       ing = 1'b0, ina = 1'b0, inb = 1'b0, mute = 1'b0;
  logic       spk, active;
  logic [2:0] note_idx;

  int errors = 0;
  int checks = 0;

  // model: 0 idle, 1 play, 2 release; tone derived from cycles since phase start
  int  half [7];
  int  freqs [7] = '{262, 294, 330, 349, 392, 440, 494};
  int  cyc = 0;
  int  m_state = 0, m_note = 0, m_start = 0, m_rel_end = 0;
  bit  m_tone = 1'b0, e_spk = 1'b0;

  note_tone_gen #(.CLK_HZ(CLK_HZ), .RELEASE_CYCLES(REL)) dut (
    .clk(clk), .reset(reset),
    .inc(inc), .ind(ind), .ine(ine), .inf(inf), .ing(ing), .ina(ina), .inb(inb),
    .mute(mute), .spk(spk), .active(active), .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  function automatic void model_edge(input logic [6:0] k, input bit m, input bit rst);
    int sel;
    sel = -1;
    if (rst) begin
      m_state = 0; m_note = 0; m_tone = 1'b0; e_spk = 1'b0;
    end else begin
      e_spk = m_tone & ~m;
      for (int i = 6; i >= 0; i--) if (k[i]) sel = i;
      if (m_state == 0) begin
        if (sel >= 0) begin m_state = 1; m_note = sel; m_start = cyc; end
      end else if (m_state == 1) begin
        if (sel >= 0) begin
          if (sel != m_note) begin m_note = sel; m_start = cyc; end
        end else if (REL == 0) m_state = 0;
        else begin m_state = 2; m_rel_end = cyc + REL; end
      end else begin
        if (sel >= 0) begin m_state = 1; m_note = sel; m_start = cyc; end
        else if (cyc == m_rel_end) m_state = 0;
      end
      m_tone = (m_state != 0) && ((((cyc - m_start) / half[m_note]) % 2) == 1);
    end
  endfunction

  function automatic logic [4:0] exp_out();
    return {e_spk, (m_state != 0), 3'(m_note)};
  endfunction

  task automatic step(input logic [6:0] k, input bit m, input bit rst);
    {inb, ina, ing, inf, ine, ind, inc} = k;
    mute  = m;
    reset = rst;
    @(posedge clk);
    cyc++;
    model_edge(k, m, rst);
    #1;
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({spk, active, note_idx} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_immediate got %b/%b/%0d want 0/0/0", spk, active, note_idx);
    end
    model_edge(7'd0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      logic [6:0] k;
      k = (i < 10) ? 7'($urandom) : 7'd0;
      step(k, 1'($urandom), (i < 10));
      checks++;
      if ({spk, active, note_idx} !== exp_out()) begin
        errors++;
        $display("FAIL reset cyc=%0d got spk/act/note=%b/%b/%0d want %b", cyc, spk, active, note_idx, exp_out());
      end
    end
  endtask

  task automatic test_single_note();
    int first_rise;
    first_rise = -1;
    for (int i = 0; i < 85; i++) begin
      step((i < 60) ? 7'b0000001 : 7'b0000000, 1'b0, 1'b0);
      if (spk && first_rise < 0) first_rise = i;
      checks++;
      if ({spk, active, note_idx} !== exp_out()) begin
        errors++;
        $display("FAIL single_c cyc=%0d got spk/act/note=%b/%b/%0d want %b", cyc, spk, active, note_idx, exp_out());
      end
    end
    checks++;
    if (first_rise != 11) begin
      errors++;
      $display("FAIL single_c_first_spk got edge %0d want edge 11", first_rise);
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 100; i++) begin
      logic [6:0] k;
      k = (i < 30) ? 7'b1000001 : ((i < 70) ? 7'b1000000 : 7'b0000000);
      step(k, 1'b0, 1'b0);
      checks++;
      if ({spk, active, note_idx} !== exp_out()) begin
        errors++;
        $display("FAIL priority cyc=%0d got spk/act/note=%b/%b/%0d want %b", cyc, spk, active, note_idx, exp_out());
      end
      if (i == 30) begin
        checks++;
        if (note_idx !== 3'd6) begin
          errors++;
          $display("FAIL priority_handover got note %0d want 6", note_idx);
        end
      end
    end
  endtask

  task automatic test_release();
    for (int i = 0; i < 85; i++) begin
      logic [6:0] k;
      k = (i < 20) ? 7'b0000100 : ((i < 28) ? 7'b0 : ((i < 58) ? 7'b0000100 : 7'b0));
      step(k, 1'b0, 1'b0);
      checks++;
      if ({spk, active, note_idx} !== exp_out()) begin
        errors++;
        $display("FAIL release cyc=%0d got spk/act/note=%b/%b/%0d want %b", cyc, spk, active, note_idx, exp_out());
      end
    end
    checks++;
    if ({spk, active} !== 2'b00) begin
      errors++;
      $display("FAIL release_expire got spk/act=%b/%b want 0/0", spk, active);
    end
  endtask

  task automatic test_mute();
    for (int i = 0; i < 80; i++) begin
      step((i < 57) ? 7'b0000001 : 7'b0, (i >= 25 && i < 32), 1'b0);
      checks++;
      if ({spk, active, note_idx} !== exp_out()) begin
        errors++;
        $display("FAIL mute cyc=%0d got spk/act/note=%b/%b/%0d want %b", cyc, spk, active, note_idx, exp_out());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 15; i++) step(7'b0000001, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    model_edge(7'd0, 1'b0, 1'b1);
    checks++;
    if ({spk, active, note_idx} !== 5'b00000) begin
      errors++;
      $display("FAIL async_reset got spk/act/note=%b/%b/%0d want 0/0/0", spk, active, note_idx);
    end
    for (int i = 0; i < 30; i++) begin
      step((i < 3) ? 7'b0 : 7'b0000001, 1'b0, (i < 3));
      checks++;
      if ({spk, active, note_idx} !== exp_out()) begin
        errors++;
        $display("FAIL async_restart cyc=%0d got spk/act/note=%b/%b/%0d want %b", cyc, spk, active, note_idx, exp_out());
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] k;
    bit         m;
    k = 7'd0;
    m = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0:       k = 7'd0;
          1:       k = 7'(1 << $urandom_range(0, 6));
          default: k = 7'($urandom);
        endcase
      end
      if ($urandom_range(0, 15) == 0) m = ~m;
      step(k, m, 1'b0);
      checks++;
      if ({spk, active, note_idx} !== exp_out()) begin
        errors++;
        $display("FAIL random cyc=%0d keys=%b mute=%b got spk/act/note=%b/%b/%0d want %b",
                 cyc, k, m, spk, active, note_idx, exp_out());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 7; i++) half[i] = CLK_HZ / (2 * freqs[i]);
    test_reset();
    test_single_note();
    test_priority();
    test_release();
    test_mute();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
